// File: rtl/game_state_ctrl.sv
// Round/level sequencer for Frogger: turns collision/restart levels into single
// game events and owns the level index, lives count and round-reset window.
module game_state_ctrl #(
    parameter int NUM_LEVELS  = 10,
    parameter int START_LIVES = 3,
    parameter int HOLD_CYCLES = 12_500_000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       win_collision,
    input  logic       death_collision,
    input  logic       restart_req,
    output logic [3:0] current_level,
    output logic [1:0] lives,
    output logic       round_reset,
    output logic       game_over,
    output logic       level_up,
    output logic       life_lost
);

    localparam int CNT_W = $clog2(HOLD_CYCLES);

    localparam logic [1:0] ST_PLAY       = 2'd0;
    localparam logic [1:0] ST_WIN_HOLD   = 2'd1;
    localparam logic [1:0] ST_DEATH_HOLD = 2'd2;
    localparam logic [1:0] ST_GAME_OVER  = 2'd3;

    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [3:0]       LEVEL_LAST = 4'(NUM_LEVELS - 1);
    localparam logic [1:0]       LIVES_INIT = 2'(START_LIVES);

    // Bit order: 0 = win, 1 = death, 2 = restart
    logic [2:0] in_vec;
    logic [2:0] edge_vec;

    assign in_vec = {restart_req, death_collision, win_collision};

    // Sample and prev both reset high so a level already high out of reset
    // has to fall before it can count as an event.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_edge
            logic sample_reg;
            logic prev_reg;

            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    sample_reg <= 1'b1;
                    prev_reg   <= 1'b1;
                end else begin
                    sample_reg <= in_vec[gi];
                    prev_reg   <= sample_reg;
                end
            end

            assign edge_vec[gi] = sample_reg & ~prev_reg;
        end
    endgenerate

    logic win_ev;
    logic death_ev;
    logic restart_ev;

    assign win_ev     = edge_vec[0];
    assign death_ev   = edge_vec[1];
    assign restart_ev = edge_vec[2];

    logic [1:0]       state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [3:0]       level_reg, level_next;
    logic [1:0]       lives_reg, lives_next;
    logic             level_up_reg, level_up_next;
    logic             life_lost_reg, life_lost_next;

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        level_next     = level_reg;
        lives_next     = lives_reg;
        level_up_next  = 1'b0;
        life_lost_next = 1'b0;

        if (restart_ev) begin
            level_next = 4'd0;
            lives_next = LIVES_INIT;
            state_next = ST_DEATH_HOLD;
            cnt_next   = '0;
        end else begin
            case (state_reg)
                ST_PLAY: begin
                    if (death_ev) begin
                        life_lost_next = 1'b1;
                        cnt_next       = '0;
                        if (lives_reg > 2'd1) begin
                            lives_next = lives_reg - 2'd1;
                            state_next = ST_DEATH_HOLD;
                        end else begin
                            lives_next = 2'd0;
                            state_next = ST_GAME_OVER;
                        end
                    end else if (win_ev) begin
                        level_up_next = 1'b1;
                        level_next    = (level_reg == LEVEL_LAST) ? 4'd0 : level_reg + 4'd1;
                        state_next    = ST_WIN_HOLD;
                        cnt_next      = '0;
                    end
                end
                ST_WIN_HOLD, ST_DEATH_HOLD: begin
                    cnt_next = cnt_reg + CNT_ONE;
                    if (cnt_reg == CNT_LAST) begin
                        state_next = ST_PLAY;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg     <= ST_PLAY;
            cnt_reg       <= '0;
            level_reg     <= 4'd0;
            lives_reg     <= LIVES_INIT;
            level_up_reg  <= 1'b0;
            life_lost_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            level_reg     <= level_next;
            lives_reg     <= lives_next;
            level_up_reg  <= level_up_next;
            life_lost_reg <= life_lost_next;
        end
    end

    assign current_level = level_reg;
    assign lives         = lives_reg;
    assign round_reset   = (state_reg != ST_PLAY);
    assign game_over     = (state_reg == ST_GAME_OVER);
    assign level_up      = level_up_reg;
    assign life_lost     = life_lost_reg;

endmodule

// File: doc/game_state_ctrl.md
# game_state_ctrl

Round/level sequencer between the collision detector and the frog, car and display logic of the Frogger top level. It converts `win_collision` and `death_collision` into single, debounced game events and owns `current_level` and the lives count. It also drives the round reset and freeze window that restart the frog and cars. It replaces the edge-clocked level counter in the top level with a single-clock synchronous FSM.

## Interface
- `NUM_LEVELS`, 10: levels before wrap to 0; legal 1..16.
- `START_LIVES`, 3: lives at game start/restart; legal 1..3.
- `HOLD_CYCLES`, 12_500_000: length of win/death hold window (0.5 s at 25 MHz); legal ≥2.

- `clk` in 1: system clock (25 MHz pixel clock domain).
- `reset_n` in 1: synchronous, active-low reset.
- `win_collision` in 1: frog in goal zone (level, from collision detector).
- `death_collision` in 1: frog hit by car (level).
- `restart_req` in 1: all four switches held (level).
- `current_level` out 4: level index 0..NUM_LEVELS-1, to VGA/car speed and 7-seg.
- `lives` out 2: remaining lives 0..START_LIVES.
- `round_reset` out 1: high while state ≠ PLAY; drives frog/car `reset`.
- `game_over` out 1: high in GAME_OVER.
- `level_up` out 1: 1-cycle pulse on accepted win.
- `life_lost` out 1: 1-cycle pulse on accepted death.

## Operation
- Edge detect: `*_prev` registers per input; event = input & ~prev. Prev registers reset to 1, so an input high out of reset must drop before it can trigger.
- States: PLAY, WIN_HOLD, DEATH_HOLD, GAME_OVER. Hold counter is `$clog2(HOLD_CYCLES)` bits, cleared on every hold entry.
- Event priority in the same cycle: restart > death > win.
- Restart event, from any state:
  - `current_level`←0, `lives`←START_LIVES.
  - Next state is DEATH_HOLD with the counter cleared.
  - No `life_lost` or `level_up` pulse.
- In PLAY, death event:
  - Pulse `life_lost`.
  - If `lives`>1: `lives`−1, go to DEATH_HOLD.
  - If `lives`==1: `lives`←0, go to GAME_OVER.
- In PLAY, win event (no death):
  - Pulse `level_up`.
  - `current_level`+1, or 0 when at NUM_LEVELS−1 (wrap).
  - Go to WIN_HOLD.
- WIN_HOLD / DEATH_HOLD:
  - Win/death events ignored.
  - Counter increments each cycle; at count==HOLD_CYCLES−1, next state is PLAY.
- GAME_OVER: win/death ignored; level and lives frozen; leaves only via restart event.
- `round_reset`, `game_over`: decoded from the state register, no combinational path from inputs.
- `level_up`, `life_lost`: registered; never both high in one cycle.

## Timing
- Reset (reset_n low at posedge) gives state PLAY, `current_level`=0, `lives`=START_LIVES, counter 0, `round_reset`=0, `game_over`=0, both pulses 0, prev regs 1.
- Reset mid-hold or in GAME_OVER aborts to PLAY with the values above.
- Latency: input rising and sampled at edge N → state, level, lives and pulse updated at edge N+1.
  - `round_reset` high from edge N+1 for exactly HOLD_CYCLES cycles.
  - PLAY is active at edge N+1+HOLD_CYCLES.
- A collision input held high across the hold and into PLAY does not retrigger; it needs a new rising edge.
- A restart during a hold restarts the counter, so the window extends to a full HOLD_CYCLES from the restart.
- Level wrap: NUM_LEVELS−1 → 0 on win; `lives` unchanged.

## Test plan
- HOLD_CYCLES=4. Reset, then a 1-cycle `win_collision` pulse → at the next edge `current_level`=1 and `level_up`=1 for 1 cycle; `round_reset`=1 for exactly 4 cycles, then PLAY.
- START_LIVES=3. Three separated death pulses → `lives` 2, 1, 0 and `life_lost` ×3; after the third, `game_over`=1 and `round_reset` stays 1 indefinitely; further win pulses leave `current_level` unchanged.
- From GAME_OVER, raise `restart_req` → `lives`=3, `current_level`=0, `round_reset` high 4 cycles, then PLAY with `game_over`=0.
- Same-cycle rising edges:
  - win+death in PLAY with `lives`=2 → `lives`=1, level unchanged, only `life_lost` pulses.
  - restart+death → `lives`=3, no pulse.
- Hold `win_collision` high through WIN_HOLD into PLAY → level increments once only. Level at 9 with NUM_LEVELS=10, then a win → `current_level`=0.
- Hold `win_collision` high across the reset deassertion → no event.
- Assert `reset_n`=0 for 1 cycle mid-DEATH_HOLD → next cycle PLAY, `lives`=3, `current_level`=0, `round_reset`=0.
